// File: rtl/fetch.sv
// Y86-64 fetch stage: byte-addressable instruction memory, instruction field
// split, next-PC computation and legality / range flags, all outputs registered.
module fetch #(
  parameter int IMEM_BYTES = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] PC_i,
  input  logic        imem_we_i,
  input  logic [63:0] imem_waddr_i,
  input  logic [7:0]  imem_wdata_i,
  output logic [3:0]  icode_o,
  output logic [3:0]  ifun_o,
  output logic [3:0]  rA_o,
  output logic [3:0]  rB_o,
  output logic [63:0] valC_o,
  output logic [63:0] valP_o,
  output logic        instr_valid_o,
  output logic        imem_error_o
);

  localparam int          AW        = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
  localparam logic [64:0] MEM_LIMIT = 65'(IMEM_BYTES);

  function automatic logic need_regids_f(input logic [3:0] icode);
    case (icode)
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: need_regids_f = 1'b1;
      default:                                 need_regids_f = 1'b0;
    endcase
  endfunction

  function automatic logic need_valc_f(input logic [3:0] icode);
    case (icode)
      4'h3, 4'h4, 4'h5, 4'h7, 4'h8: need_valc_f = 1'b1;
      default:                     need_valc_f = 1'b0;
    endcase
  endfunction

  logic [7:0]  mem_r [IMEM_BYTES];
  logic [64:0] baddr_s [10];
  logic [7:0]  byte_s [10];

  // Up to ten bytes of the instruction; bytes past the end of memory read as 0.
  for (genvar k = 0; k < 10; k++) begin : g_bytes
    assign baddr_s[k] = {1'b0, PC_i} + 65'(k);
    assign byte_s[k]  = (baddr_s[k] < MEM_LIMIT) ? mem_r[baddr_s[k][AW-1:0]] : 8'h00;
  end

  // Instruction memory byte write; out-of-range addresses are dropped.
  always_ff @(posedge clk_i) begin
    if (imem_we_i && ({1'b0, imem_waddr_i} < MEM_LIMIT)) begin
      mem_r[imem_waddr_i[AW-1:0]] <= imem_wdata_i;
    end
  end

  logic [3:0]  raw_icode_s;
  logic        need_regids_s;
  logic        need_valc_s;
  logic [3:0]  len_s;
  logic [64:0] last_s;
  logic        err_s;
  logic [3:0]  icode_s, ifun_s, ra_s, rb_s;
  logic [63:0] valc_s, valp_s;
  logic        valid_s;

  // Decode the fetched bytes into next-cycle output values.
  always_comb begin
    raw_icode_s   = byte_s[0][7:4];
    need_regids_s = need_regids_f(raw_icode_s);
    need_valc_s   = need_valc_f(raw_icode_s);
    len_s         = 4'd1 + {3'b000, need_regids_s} + (need_valc_s ? 4'd8 : 4'd0);
    // 65-bit so an instruction running past 2^64 cannot wrap into range.
    last_s        = {1'b0, PC_i} + {61'b0, len_s} - 65'd1;
    err_s         = (last_s >= MEM_LIMIT);
    icode_s       = 4'h1;
    ifun_s        = 4'h0;
    ra_s          = 4'hF;
    rb_s          = 4'hF;
    valc_s        = 64'h0;
    valp_s        = PC_i + 64'd1;
    valid_s       = 1'b0;
    if (err_s) begin
      icode_s = 4'h1;
      valp_s  = PC_i + 64'd1;
    end else begin
      icode_s = raw_icode_s;
      ifun_s  = byte_s[0][3:0];
      valp_s  = PC_i + {60'b0, len_s};
      valid_s = (raw_icode_s <= 4'hB);
      if (need_regids_s) begin
        ra_s = byte_s[1][7:4];
        rb_s = byte_s[1][3:0];
      end else begin
        ra_s = 4'hF;
        rb_s = 4'hF;
      end
      if (need_valc_s && need_regids_s) begin
        valc_s = {byte_s[9], byte_s[8], byte_s[7], byte_s[6],
                  byte_s[5], byte_s[4], byte_s[3], byte_s[2]};
      end else if (need_valc_s) begin
        valc_s = {byte_s[8], byte_s[7], byte_s[6], byte_s[5],
                  byte_s[4], byte_s[3], byte_s[2], byte_s[1]};
      end else begin
        valc_s = 64'h0;
      end
    end
  end

  // Output register; reset clears every output field.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      icode_o       <= 4'h0;
      ifun_o        <= 4'h0;
      rA_o          <= 4'h0;
      rB_o          <= 4'h0;
      valC_o        <= 64'h0;
      valP_o        <= 64'h0;
      instr_valid_o <= 1'b0;
      imem_error_o  <= 1'b0;
    end else begin
      icode_o       <= icode_s;
      ifun_o        <= ifun_s;
      rA_o          <= ra_s;
      rB_o          <= rb_s;
      valC_o        <= valc_s;
      valP_o        <= valp_s;
      instr_valid_o <= valid_s;
      imem_error_o  <= err_s;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: directed Y86-64 cases with literal expectations
// plus randomized traffic compared every cycle against a table-driven model.
module tb_fetch;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [63:0] PC_i;
  logic        imem_we_i;
  logic [63:0] imem_waddr_i;
  logic [7:0]  imem_wdata_i;
  logic [3:0]  icode_o, ifun_o, rA_o, rB_o;
  logic [63:0] valC_o, valP_o;
  logic        instr_valid_o, imem_error_o;

  int tests_run    = 0;
  int tests_failed = 0;

  fetch #(.IMEM_BYTES(256)) dut (
    .clk_i(clk), .rst_i(rst_i), .PC_i(PC_i),
    .imem_we_i(imem_we_i), .imem_waddr_i(imem_waddr_i), .imem_wdata_i(imem_wdata_i),
    .icode_o(icode_o), .ifun_o(ifun_o), .rA_o(rA_o), .rB_o(rB_o),
    .valC_o(valC_o), .valP_o(valP_o),
    .instr_valid_o(instr_valid_o), .imem_error_o(imem_error_o)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Instruction length by icode: halt nop rrmov irmov rmmov mrmov op jxx call ret push pop, then illegal.
  int          len_tab [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};
  logic [7:0]  mdl_mem [256];
  logic        mdl_ok = 1'b0;
  logic [3:0]  e_icode, e_ifun, e_ra, e_rb;
  logic [63:0] e_valc, e_valp;
  logic        e_valid, e_err;
  logic [7:0]  m_b0, m_b1;
  logic [64:0] m_last;
  int          m_len;

  function automatic logic [7:0] rd(input logic [64:0] a);
    rd = (a < 65'd256) ? mdl_mem[a[7:0]] : 8'h00;
  endfunction

  always @(posedge clk) begin
    if (rst_i) begin
      e_icode = 0; e_ifun = 0; e_ra = 0; e_rb = 0;
      e_valc = 0; e_valp = 0; e_valid = 0; e_err = 0;
    end else begin
      m_b0   = rd({1'b0, PC_i});
      m_len  = len_tab[m_b0[7:4]];
      m_last = {1'b0, PC_i} + 65'(m_len) - 65'd1;
      if (m_last >= 65'd256) begin
        e_icode = 4'h1; e_ifun = 4'h0; e_ra = 4'hF; e_rb = 4'hF;
        e_valc = 64'd0; e_valp = PC_i + 64'd1; e_valid = 1'b0; e_err = 1'b1;
      end else begin
        e_icode = m_b0[7:4];
        e_ifun  = m_b0[3:0];
        e_valid = (m_b0[7:4] <= 4'hB);
        e_err   = 1'b0;
        e_valp  = PC_i + 64'(m_len);
        m_b1    = rd({1'b0, PC_i} + 65'd1);
        e_ra    = (m_len == 2 || m_len == 10) ? m_b1[7:4] : 4'hF;
        e_rb    = (m_len == 2 || m_len == 10) ? m_b1[3:0] : 4'hF;
        e_valc  = 64'd0;
        // The constant always occupies the last eight bytes of the instruction.
        if (m_len >= 9)
          for (int i = 0; i < 8; i++)
            e_valc = e_valc | (64'(rd({1'b0, PC_i} + 65'(m_len - 8 + i))) << (8 * i));
      end
    end
    if (imem_we_i && imem_waddr_i < 64'd256) mdl_mem[imem_waddr_i[7:0]] = imem_wdata_i;
    mdl_ok = 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (mdl_ok) begin
      chk("icode", 64'(icode_o), 64'(e_icode));
      chk("ifun",  64'(ifun_o),  64'(e_ifun));
      chk("rA",    64'(rA_o),    64'(e_ra));
      chk("rB",    64'(rB_o),    64'(e_rb));
      chk("valC",  valC_o,       e_valc);
      chk("valP",  valP_o,       e_valp);
      chk("valid", 64'(instr_valid_o), 64'(e_valid));
      chk("err",   64'(imem_error_o),  64'(e_err));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wr(input logic [63:0] a, input logic [7:0] d);
    @(negedge clk);
    imem_we_i = 1'b1; imem_waddr_i = a; imem_wdata_i = d;
  endtask

  task automatic lit(input string n, input logic [3:0] ic, input logic [3:0] fn,
                     input logic [3:0] ra, input logic [3:0] rb,
                     input logic [63:0] vc, input logic [63:0] vp,
                     input logic v, input logic e);
    chk({n, ".icode"}, 64'(icode_o), 64'(ic));
    chk({n, ".ifun"},  64'(ifun_o),  64'(fn));
    chk({n, ".rA"},    64'(rA_o),    64'(ra));
    chk({n, ".rB"},    64'(rB_o),    64'(rb));
    chk({n, ".valC"},  valC_o,       vc);
    chk({n, ".valP"},  valP_o,       vp);
    chk({n, ".valid"}, 64'(instr_valid_o), 64'(v));
    chk({n, ".err"},   64'(imem_error_o),  64'(e));
  endtask

  task automatic fetch_at(input logic [63:0] pc);
    @(negedge clk);
    imem_we_i = 1'b0; PC_i = pc;
    @(negedge clk);
  endtask

  logic [7:0] irmov [10];
  logic [7:0] jne   [9];

  initial begin
    irmov = '{8'h30, 8'hF2, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    jne   = '{8'h74, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    rst_i = 1'b1; PC_i = 64'd0; imem_we_i = 1'b0; imem_waddr_i = 64'd0; imem_wdata_i = 8'h00;
    // Clear the memory while held in reset.
    for (int a = 0; a < 256; a++) wr(64'(a), 8'h00);
    @(negedge clk); imem_we_i = 1'b0;
    @(negedge clk);
    lit("reset", 4'h0, 4'h0, 4'h0, 4'h0, 64'h0, 64'h0, 1'b0, 1'b0);
    rst_i = 1'b0;

    for (int i = 0; i < 10; i++) wr(64'(i), irmov[i]);
    // Latency: PC applied at this negedge must not show before the next edge.
    fetch_at(64'd70);
    @(negedge clk); PC_i = 64'd0;
    chk("latency.valP_old", valP_o, 64'h47);
    @(negedge clk);
    lit("irmovq", 4'h3, 4'h0, 4'hF, 4'h2, 64'hA, 64'hA, 1'b1, 1'b0);

    wr(64'd20, 8'h60); wr(64'd21, 8'h20);
    fetch_at(64'd20);
    lit("addq", 4'h6, 4'h0, 4'h2, 4'h0, 64'h0, 64'h16, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) wr(64'(46 + i), jne[i]);
    fetch_at(64'd46);
    lit("jne", 4'h7, 4'h4, 4'hF, 4'hF, 64'h40, 64'h37, 1'b1, 1'b0);

    wr(64'd64, 8'h90); wr(64'd65, 8'h10); wr(64'd66, 8'h00);
    fetch_at(64'd64); lit("ret",  4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h41, 1'b1, 1'b0);
    fetch_at(64'd65); lit("nop",  4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h42, 1'b1, 1'b0);
    fetch_at(64'd66); lit("halt", 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h43, 1'b1, 1'b0);

    fetch_at(64'd256);
    lit("pc256", 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h101, 1'b0, 1'b1);
    wr(64'd250, 8'h30); wr(64'd251, 8'hF2);
    fetch_at(64'd250);
    lit("irmov250", 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'hFB, 1'b0, 1'b1);
    wr(64'd255, 8'h10);
    fetch_at(64'd255);
    lit("nop255", 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h100, 1'b1, 1'b0);
    fetch_at(64'hFFFF_FFFF_FFFF_FFFF);
    lit("pcmax", 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0, 1'b1);

    wr(64'd70, 8'hC0);
    fetch_at(64'd70);
    lit("illegal", 4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h47, 1'b0, 1'b0);
    // Overwrite the byte being fetched in the same cycle.
    @(negedge clk);
    PC_i = 64'd70; imem_we_i = 1'b1; imem_waddr_i = 64'd70; imem_wdata_i = 8'h10;
    @(negedge clk); imem_we_i = 1'b0;
    chk("collide.old", 64'(icode_o), 64'hC);
    @(negedge clk);
    chk("collide.new", 64'(icode_o), 64'h1);

    // Mid-stream reset, then memory must still hold irmovq.
    @(negedge clk); PC_i = 64'd0; rst_i = 1'b1;
    @(negedge clk); rst_i = 1'b0;
    lit("midreset", 4'h0, 4'h0, 4'h0, 4'h0, 64'h0, 64'h0, 1'b0, 1'b0);
    @(negedge clk);
    lit("retained", 4'h3, 4'h0, 4'hF, 4'h2, 64'hA, 64'hA, 1'b1, 1'b0);

    // Randomized traffic checked by the per-cycle model.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst_i        = ($urandom_range(0, 59) == 0);
      imem_we_i    = ($urandom_range(0, 2) != 0);
      imem_waddr_i = ($urandom_range(0, 19) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 270));
      imem_wdata_i = 8'($urandom);
      case ($urandom_range(0, 9))
        0:       PC_i = {$urandom, $urandom};
        1:       PC_i = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
        2:       PC_i = 64'($urandom_range(240, 260));
        default: PC_i = 64'($urandom_range(0, 255));
      endcase
    end
    @(negedge clk); rst_i = 1'b0; imem_we_i = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch.md
Name: fetch

Overview:
- Fetch stage of the Y86-64 processor.
- Holds a byte-addressable instruction memory and splits the instruction at PC_i into icode, ifun, rA, rB, valC and valP.
- Also flags illegal instruction codes and out-of-range fetches.
- Outputs are registered; the decode stage consumes them.

Parameters:
- IMEM_BYTES, 256, size of the instruction memory in bytes; valid addresses are 0..IMEM_BYTES-1.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- PC_i  input  64  address of the instruction to fetch.
- imem_we_i  input  1  instruction-memory byte write enable.
- imem_waddr_i  input  64  write byte address.
- imem_wdata_i  input  8  write data byte.
- icode_o  output  4  instruction code (byte0[7:4]).
- ifun_o  output  4  function code (byte0[3:0]).
- rA_o  output  4  register A (byte1[7:4]), or 0xF if the instruction has no register byte.
- rB_o  output  4  register B (byte1[3:0]), or 0xF if the instruction has no register byte.
- valC_o  output  64  little-endian 8-byte constant, 0 if the instruction has none.
- valP_o  output  64  address of the next sequential instruction.
- instr_valid_o  output  1  1 when icode is legal.
- imem_error_o  output  1  1 when the instruction extends past memory.

Behaviour:
- Reset: when rst_i=1 at a rising edge, all outputs load 0 (icode, ifun, rA, rB, valC, valP, instr_valid, imem_error).
  - Memory contents are not affected by reset.
  - Reset has priority over fetch.
- Latency: one cycle. Outputs sampled after edge N reflect PC_i and memory contents present before edge N.
- Memory writes:
  - When imem_we_i=1 and imem_waddr_i < IMEM_BYTES, the byte is written at the edge; writes to out-of-range addresses are ignored.
  - A fetch in the same cycle reads the old byte (read-before-write).
  - Writes are honoured even while rst_i=1.
- Uninitialised memory reads as 0.
- Encoding:
  - need_regids = icode ∈ {2,3,4,5,6,A,B}.
  - need_valC = icode ∈ {3,4,5,7,8}.
  - Length = 1 + need_regids + 8·need_valC.
- Field extraction:
  - valC is taken from bytes PC+1+need_regids .. +7, least-significant byte first.
  - valP = PC_i + length, as a 64-bit sum.
- instr_valid_o = 1 iff icode ≤ 0xB; ifun is not checked.
- Illegal icode (0xC–0xF):
  - instr_valid_o=0.
  - Length is 1, so valP=PC+1.
  - rA=rB=0xF, valC=0.
- imem_error_o = 1 if PC_i ≥ IMEM_BYTES, or if PC_i+length−1 ≥ IMEM_BYTES.
  - The comparison is done without 64-bit wrap, i.e. in 65-bit arithmetic.
- On imem_error:
  - icode=1 (nop), ifun=0, rA=rB=0xF, valC=0.
  - instr_valid_o=0.
  - valP=PC_i+1.

Test Plan:
- Reset: hold rst_i=1 for 2 cycles → all outputs 0. Assert rst_i mid-stream → outputs 0 on the next edge; memory retains its data.
- Load irmovq: write 30 F2 0A 00 00 00 00 00 00 00 at address 0; PC_i=0 → icode=3, ifun=0, rA=F, rB=2, valC=0xA, valP=0xA, valid=1, err=0. Outputs appear exactly one edge after PC_i is applied.
- addq and jne: write 60 20 at 20; PC=20 → icode=6, ifun=0, rA=2, rB=0, valC=0, valP=0x16. Write 74 40 00 00 00 00 00 00 00 at 46; PC=46 → icode=7, ifun=4, rA=F, rB=F, valC=0x40, valP=0x37.
- One-byte instructions: ret (90) at 64 → valP=0x41. nop (10) at 65 → valP=0x42. halt (00) at 66 → icode=0, valP=0x43, valid=1.
- Errors: PC=256 → err=1, icode=1, rA=rB=F, valC=0, valid=0, valP=0x101. irmovq at 250 (needs bytes to 259) → err=1. PC=0xFFFFFFFFFFFFFFFF → err=1.
- Illegal icode and write collision: byte C0 at 70, PC=70 → valid=0, err=0, valP=0x47, rA=rB=F. Write 10 to 70 in the same cycle as fetching 70 → the first result still shows icode C; the next cycle shows icode 1.
